// File: rtl/topk_pkg.sv
// +----------------------------------------------------------------------+
// | topk_pkg: shared types and helpers for the top-k launch scheduler.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package topk_pkg;

    localparam int MAX_SLOTS = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATHER = 2'd1,
        S_ISSUE  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [5:0] len;
        logic [5:0] k;
        logic       sign;
    } sched_key_t;

    typedef struct packed {
        logic                         valid;
        logic [3:0]                   group;
        logic [MAX_SLOTS-1:0][2:0]    req;
    } sched_tag_t;

    function automatic logic len_is_legal(input logic [5:0] len);
        return (len == 6'd4) || (len == 6'd8) || (len == 6'd16) || (len == 6'd32);
    endfunction

    // Groups that fit in the 32-element sorter, limited by the requester count.
    function automatic logic [3:0] cap_for_len(input logic [5:0] len, input int num_req);
        logic [3:0] slots;
        case (len)
            6'd4:    slots = 4'd8;
            6'd8:    slots = 4'd4;
            6'd16:   slots = 4'd2;
            default: slots = 4'd1;
        endcase
        return (int'(slots) < num_req) ? slots : 4'(num_req);
    endfunction

endpackage

`default_nettype wire

// File: rtl/topk_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | topk_rr_arbiter: round-robin grant plus rotated priority order.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module topk_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [IDX_W-1:0]              ptr_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          any_o,
    output logic [NUM_REQ-1:0][IDX_W-1:0] order_o
);

    logic [3:0] pos;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        order_o     = '0;
        pos         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = 4'(ptr_i) + 4'(i);
            if (pos >= 4'(NUM_REQ)) begin
                pos = pos - 4'(NUM_REQ);
            end
            order_o[i] = pos[IDX_W-1:0];
            if (!any_o && req_i[pos[IDX_W-1:0]]) begin
                any_o                       = 1'b1;
                grant_idx_o                 = pos[IDX_W-1:0];
                grant_o[pos[IDX_W-1:0]]     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/topk_launch_scheduler.sv
// +----------------------------------------------------------------------+
// | topk_launch_scheduler: packs same-key requests into sorter launches  |
// | and tags results. Optional macro: TOPK_SCHED_PERF_EN (perf counters).|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module topk_launch_scheduler
    import topk_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 4,
    parameter int SORT_LATENCY = 6,
    parameter int GATHER_WAIT  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][5:0]           req_len_i,
    input  logic [NUM_REQ-1:0][5:0]           req_k_i,
    input  logic [NUM_REQ-1:0]                req_sign_i,
    input  logic [NUM_REQ-1:0][ID_W-1:0]      req_id_i,
    output logic                              sort_valid_o,
    output logic [5:0]                        sort_length_o,
    output logic [3:0]                        sort_group_o,
    output logic [5:0]                        sort_k_o,
    output logic                              sort_sign_o,
    output logic [MAX_SLOTS-1:0][2:0]         slot_src_o,
    output logic                              rsp_valid_o,
    output logic [3:0]                        rsp_group_o,
    output logic [MAX_SLOTS-1:0][2:0]         rsp_req_o,
    output logic [MAX_SLOTS-1:0][ID_W-1:0]    rsp_id_o,
    output logic                              err_o,
    output logic [2:0]                        err_req_o
`ifdef TOPK_SCHED_PERF_EN
    ,
    output logic [31:0]                       perf_launch_o,
    output logic [31:0]                       perf_lists_o
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (GATHER_WAIT > 1) ? $clog2(GATHER_WAIT) : 1;

    typedef struct packed {
        sched_tag_t                      meta;
        logic [MAX_SLOTS-1:0][ID_W-1:0]  id;
    } tag_t;

    sched_state_t                   state_q, state_d;
    logic [IDX_W-1:0]               rr_q, rr_d, leader_q, leader_d;
    sched_key_t                     key_q, key_d;
    logic [NUM_REQ-1:0]             mask_q, mask_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    tag_t [SORT_LATENCY-1:0]        pipe_q;
    tag_t                           tag_d;

    logic [IDX_W-1:0]               w_arb_ptr, w_gidx, w_idx;
    logic [NUM_REQ-1:0]             w_grant;
    logic                           w_any;
    logic [NUM_REQ-1:0][IDX_W-1:0]  w_order;
    logic [3:0]                     w_pop, w_cap;
    logic [5:0]                     w_lead_len, w_lead_k;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
        return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + IDX_W'(1);
    endfunction

    // Leader search rotates from rr; once a leader exists, ordering is from the leader.
    assign w_arb_ptr = (state_q == S_IDLE) ? rr_q : leader_q;

    topk_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (w_arb_ptr),
        .grant_o     (w_grant),
        .grant_idx_o (w_gidx),
        .any_o       (w_any),
        .order_o     (w_order)
    );

    assign w_lead_len = req_len_i[w_gidx];
    assign w_lead_k   = req_k_i[w_gidx];

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        leader_d      = leader_q;
        key_d         = key_q;
        mask_d        = mask_q;
        cnt_d         = cnt_q;
        tag_d         = '0;
        req_ready_o   = '0;
        err_o         = 1'b0;
        err_req_o     = '0;
        sort_valid_o  = 1'b0;
        sort_length_o = '0;
        sort_group_o  = '0;
        sort_k_o      = '0;
        sort_sign_o   = 1'b0;
        slot_src_o    = '0;
        w_idx         = '0;
        w_pop         = '0;
        w_cap         = cap_for_len(key_q.len, NUM_REQ);

        unique case (state_q)
            S_IDLE: begin
                if (w_any && !rst_i) begin
                    if (!len_is_legal(w_lead_len) || (w_lead_k == 6'd0) || (w_lead_k > w_lead_len)) begin
                        req_ready_o = w_grant;
                        err_o       = 1'b1;
                        err_req_o   = 3'(w_gidx);
                        rr_d        = next_idx(w_gidx);
                    end else begin
                        key_d    = '{len: w_lead_len, k: w_lead_k, sign: req_sign_i[w_gidx]};
                        leader_d = w_gidx;
                        mask_d   = w_grant;
                        cnt_d    = '0;
                        state_d  = (cap_for_len(w_lead_len, NUM_REQ) == 4'd1) ? S_ISSUE : S_GATHER;
                    end
                end
            end

            S_GATHER: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (mask_q[i]) begin
                        w_pop = w_pop + 4'd1;
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    w_idx = w_order[i];
                    if (req_valid_i[w_idx] && !mask_d[w_idx] && (w_pop < w_cap) &&
                        (req_len_i[w_idx] == key_q.len) && (req_k_i[w_idx] == key_q.k) &&
                        (req_sign_i[w_idx] == key_q.sign)) begin
                        mask_d[w_idx] = 1'b1;
                        w_pop         = w_pop + 4'd1;
                    end
                end
                if ((w_pop == w_cap) || (cnt_q == CNT_W'(GATHER_WAIT - 1))) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ISSUE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    w_idx = w_order[i];
                    if (mask_q[w_idx]) begin
                        slot_src_o[w_pop[2:0]] = 3'(w_idx);
                        tag_d.id[w_pop[2:0]]   = req_id_i[w_idx];
                        w_pop                  = w_pop + 4'd1;
                    end
                end
                sort_valid_o   = 1'b1;
                sort_length_o  = key_q.len;
                sort_k_o       = key_q.k;
                sort_sign_o    = key_q.sign;
                sort_group_o   = w_pop;
                req_ready_o    = mask_q;
                tag_d.meta     = '{valid: 1'b1, group: w_pop, req: slot_src_o};
                rr_d           = next_idx(leader_q);
                mask_d         = '0;
                state_d        = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            leader_q <= '0;
            key_q    <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            pipe_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            leader_q <= leader_d;
            key_q    <= key_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            pipe_q[0] <= tag_d;
            for (int i = 1; i < SORT_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rsp_valid_o = pipe_q[SORT_LATENCY-1].meta.valid;
    assign rsp_group_o = pipe_q[SORT_LATENCY-1].meta.group;
    assign rsp_req_o   = pipe_q[SORT_LATENCY-1].meta.req;
    assign rsp_id_o    = pipe_q[SORT_LATENCY-1].id;

`ifdef TOPK_SCHED_PERF_EN
    logic [31:0] perf_launch_q, perf_lists_q;
    logic [32:0] w_lists_sum;

    assign w_lists_sum = {1'b0, perf_lists_q} + 33'(sort_group_o);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_launch_q <= '0;
            perf_lists_q  <= '0;
        end else if (sort_valid_o) begin
            if (perf_launch_q != '1) begin
                perf_launch_q <= perf_launch_q + 32'd1;
            end
            perf_lists_q <= w_lists_sum[32] ? '1 : w_lists_sum[31:0];
        end
    end

    assign perf_launch_o = perf_launch_q;
    assign perf_lists_o  = perf_lists_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: doc/topk_launch_scheduler.md
Name: topk_launch_scheduler

Overview:
- Shares the top-k sorter datapath (sorter plus top-k selection) between NUM_REQ requesters.
- Each request is one list with its own length, k, sign mode and ID. Requests with an identical key {length, k, sign} are packed into one sorter launch as parallel groups.
- Drives the launch controls and the per-slot source select for the input mux.
- Carries request IDs through a tag pipeline matched to the sorter latency, so every result returns labelled with its originating requester and ID.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 4: request ID width.
- SORT_LATENCY, 6: fixed cycles from sort_valid_o to the result at the top-k output, ≥1.
- GATHER_WAIT, 4: maximum cycles spent collecting same-key requests, ≥1.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous, active-high reset.
- req_valid_i, in, [NUM_REQ]: request valid.
- req_ready_o, out, [NUM_REQ]: request accepted; transfer occurs when valid && ready.
- req_len_i, in, [NUM_REQ][6]: list length.
- req_k_i, in, [NUM_REQ][6]: k.
- req_sign_i, in, [NUM_REQ]: 1 = signed compare.
- req_id_i, in, [NUM_REQ][ID_W]: request ID.
- sort_valid_o, out, 1: launch strobe to the sorter.
- sort_length_o, out, 6: drives total_length_i.
- sort_group_o, out, 4: drives total_group_i.
- sort_k_o, out, 6: drives k_i.
- sort_sign_o, out, 1: drives sign_ctrl_i.
- slot_src_o, out, [8][3]: requester index feeding group slot g.
- rsp_valid_o, out, 1: result present at the top-k output.
- rsp_group_o, out, 4: number of valid groups in the result.
- rsp_req_o, out, [8][3]: requester per group.
- rsp_id_o, out, [8][ID_W]: ID per group.
- err_o, out, 1: illegal request dropped.
- err_req_o, out, 3: index of the dropped requester.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, rr pointer is 0, the tag pipeline is cleared.
- Legal request: len ∈ {4, 8, 16, 32} and 1 ≤ k ≤ len.
- Capacity: cap = min(NUM_REQ, 32/len).
- Requesters must hold valid and all fields stable until ready. Each requester contributes at most one list per launch.
- FSM states: IDLE, GATHER, ISSUE.
- IDLE:
  - The round-robin arbiter (start at rr pointer) picks a leader among valid requesters.
  - If the leader is illegal: pulse req_ready_o[leader], err_o and err_req_o for 1 cycle, drop the request, advance rr to leader+1, stay in IDLE.
  - If the leader is legal: register the key, set mask = {leader}. Go to ISSUE if cap == 1, otherwise go to GATHER.
- GATHER:
  - Each cycle, add valid requesters whose key equals the registered key and that are not yet in mask, in rr order from the leader, until mask popcount reaches cap.
  - A wait counter starts at 0 on entry.
  - Go to ISSUE at the end of any cycle where popcount == cap, or when the counter reaches GATHER_WAIT-1.
  - Non-matching requesters wait.
- ISSUE (1 cycle):
  - sort_valid_o = 1; sort_* outputs carry the key; sort_group_o = popcount.
  - slot_src_o[g] = the g-th mask member in rr order from the leader. Unused slots are 0.
  - req_ready_o = mask, so the datapath samples the requester data this same cycle.
  - Set rr = leader+1 mod NUM_REQ, go to IDLE.
  - Outside ISSUE, sort_* outputs are 0.
- Tag pipeline: a SORT_LATENCY-deep shift register of {valid, group, req[], id[]}, loaded on ISSUE. rsp_* appears exactly SORT_LATENCY cycles after sort_valid_o, for one cycle.
- Launches may overlap in the pipeline without limit. There is no output backpressure.
- Reset mid-operation clears mask, counter and tags. No rsp_valid_o is emitted for pre-reset launches.
- Earliest launch timing: a leader picked at cycle t gives ISSUE at t+1 (cap == 1), t+2 (full after the first GATHER cycle), or t+GATHER_WAIT+1 (timeout).

Optional Feature:
- Macro: TOPK_SCHED_PERF_EN.
- When defined: ports perf_launch_o [32] and perf_lists_o [32] are added. They are saturating counters of issued launches and of accepted legal lists, cleared by rst_i.
- When undefined: the ports and the counters are absent.

Decomposition:
- Into topk_pkg:
  - sched_key_t {len, k, sign}.
  - sched_tag_t.
  - Constant MAX_SLOTS = 8.
  - Functions len_is_legal() and cap_for_len().
- Sub-module topk_rr_arbiter: parameterised NUM_REQ; inputs request vector and pointer; outputs one-hot grant plus a rotated priority order, used both for leader pick and slot ordering.

Test Plan (NUM_REQ=4, SORT_LATENCY=6, GATHER_WAIT=4):
- Reset asserted mid-run → all outputs 0 immediately; no rsp_valid_o afterwards despite 2 launches in flight.
- req0 len=16 k=5 sign=0 id=3 at cycle t → sort_valid_o at t+5 with length 16, group 1, k 5; req_ready_o[0] at t+5; rsp_valid_o at t+11 with rsp_req_o[0]=0 and rsp_id_o[0]=3.
- req0..3 all len=8 k=2 sign=1 at t → ISSUE at t+2, group 4, slot_src_o = 0,1,2,3; req_ready_o = 4'b1111 at t+2.
- req0 len=8 and req1 len=16 simultaneously, rr=0 → first launch length 8 group 1; second launch length 16 from req1 afterwards; rr ends at 2.
- req2 len=12 → err_o = 1 and err_req_o = 2 for one cycle; req_ready_o[2] pulses; no sort_valid_o.
- req3 len=32 k=32 → ISSUE at t+1 (GATHER bypassed), group 1.
